// File: rtl/control_logic.sv
// rtl/control_logic.sv - in-order pipeline interlock: destination-mask tracking, RAW hazard detection, stage holds
module control_logic #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [NREGS-1:0] id_out_request,
  input  logic [NREGS-1:0] id_out_provide,
  input  logic             ext_stall,
  output logic             cl_out_nop_id_stat,
  output logic             cl_out_nop_of_stat,
  output logic             cl_out_nop_ex_stat,
  output logic             cl_out_nop_wb_stat,
  output logic [NREGS-1:0] busy_mask,
  output logic [NREGS-1:0] hazard_mask
);

  // Destination masks of the instructions currently sitting in OF, EX and WB.
  logic [NREGS-1:0] r_of_mask;
  logic [NREGS-1:0] r_ex_mask;
  logic [NREGS-1:0] r_wb_mask;

  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_hazard_mask;
  logic             w_hazard;
  logic [NREGS-1:0] w_of_next;

  // WB still counts as busy: the register file is only written at the end of that cycle,
  // and there is no forwarding path, so a reader must wait until the producer leaves WB.
  assign w_busy        = r_of_mask | r_ex_mask | r_wb_mask;
  assign w_hazard_mask = id_valid ? (id_out_request & w_busy) : '0;
  assign w_hazard      = |w_hazard_mask;

  // A stalled or empty ID slot injects a bubble into OF.
  assign w_of_next     = (id_valid && !w_hazard) ? id_out_provide : '0;

  assign busy_mask     = w_busy;
  assign hazard_mask   = w_hazard_mask;

  // Stage holds: external freeze wins over the interlock; everything is quiet in reset.
  always_comb begin
    cl_out_nop_id_stat = 1'b0;
    cl_out_nop_of_stat = 1'b0;
    cl_out_nop_ex_stat = 1'b0;
    cl_out_nop_wb_stat = 1'b0;
    if (!reset) begin
      cl_out_nop_id_stat = 1'b0;
    end else if (ext_stall) begin
      cl_out_nop_id_stat = 1'b1;
      cl_out_nop_of_stat = 1'b1;
      cl_out_nop_ex_stat = 1'b1;
      cl_out_nop_wb_stat = 1'b1;
    end else if (w_hazard) begin
      cl_out_nop_id_stat = 1'b1;
    end
  end

  // Advance the mask pipeline unless frozen; reset clears all in-flight state at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_of_mask <= '0;
      r_ex_mask <= '0;
      r_wb_mask <= '0;
    end else if (!ext_stall) begin
      r_of_mask <= w_of_next;
      r_ex_mask <= r_of_mask;
      r_wb_mask <= r_ex_mask;
    end
  end

endmodule

// File: tb/tb_control_logic.sv
// tb/tb_control_logic.sv - scoreboard bench for control_logic
module tb_control_logic;

  localparam int NREGS = 16;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [NREGS-1:0] id_out_request;
  logic [NREGS-1:0] id_out_provide;
  logic             ext_stall;
  logic             cl_out_nop_id_stat;
  logic             cl_out_nop_of_stat;
  logic             cl_out_nop_ex_stat;
  logic             cl_out_nop_wb_stat;
  logic [NREGS-1:0] busy_mask;
  logic [NREGS-1:0] hazard_mask;

  control_logic #(.NREGS(NREGS)) dut (
    .clk                (clk),
    .reset              (reset),
    .id_valid           (id_valid),
    .id_out_request     (id_out_request),
    .id_out_provide     (id_out_provide),
    .ext_stall          (ext_stall),
    .cl_out_nop_id_stat (cl_out_nop_id_stat),
    .cl_out_nop_of_stat (cl_out_nop_of_stat),
    .cl_out_nop_ex_stat (cl_out_nop_ex_stat),
    .cl_out_nop_wb_stat (cl_out_nop_wb_stat),
    .busy_mask          (busy_mask),
    .hazard_mask        (hazard_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] hmask;
    logic [3:0]       nops;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [NREGS-1:0] m_of, m_ex, m_wb;
  logic             obs_nop_id;
  logic [NREGS-1:0] obs_busy;
  int               stall_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference expectation from the bench's own mask model and current stimulus.
  task automatic push_expect(input string tag);
    exp_t e;
    logic [NREGS-1:0] b;
    b = m_of | m_ex | m_wb;
    e.tag   = tag;
    e.busy  = b;
    e.hmask = id_valid ? (id_out_request & b) : '0;
    if (!reset)              e.nops = 4'b0000;
    else if (ext_stall)      e.nops = 4'b1111;
    else if (|e.hmask)       e.nops = 4'b1000;
    else                     e.nops = 4'b0000;
    sb_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_busy"}, 32'(busy_mask), 32'(e.busy));
      check_eq({e.tag, "_hmask"}, 32'(hazard_mask), 32'(e.hmask));
      check_eq({e.tag, "_nops"},
               {28'd0, cl_out_nop_id_stat, cl_out_nop_of_stat, cl_out_nop_ex_stat, cl_out_nop_wb_stat},
               {28'd0, e.nops});
    end
    obs_nop_id = cl_out_nop_id_stat;
    obs_busy   = busy_mask;
  endtask

  task automatic model_edge(input logic v, input logic [NREGS-1:0] rq, input logic [NREGS-1:0] pv,
                            input logic st);
    logic haz;
    haz = v && |(rq & (m_of | m_ex | m_wb));
    if (!st) begin
      m_wb = m_ex;
      m_ex = m_of;
      m_of = (v && !haz) ? pv : '0;
    end
  endtask

  // One clock: drive at negedge, compare mid-low-phase, update model at posedge.
  task automatic step(input string tag, input logic v, input logic [NREGS-1:0] rq,
                      input logic [NREGS-1:0] pv, input logic st);
    id_valid       = v;
    id_out_request = rq;
    id_out_provide = pv;
    ext_stall      = st;
    push_expect(tag);
    #2;
    pop_compare();
    @(posedge clk);
    model_edge(v, rq, pv, st);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, '0, '0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset     = 1'b0;
    ext_stall = 1'b1;
    id_valid  = 1'b1;
    id_out_request = '1;
    m_of = '0; m_ex = '0; m_wb = '0;
    push_expect(tag);
    #1;
    pop_compare();
    @(posedge clk);
    @(negedge clk);
    push_expect({tag, "_hold"});
    #1;
    pop_compare();
    reset     = 1'b1;
    ext_stall = 1'b0;
    id_valid  = 1'b0;
    id_out_request = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_out_request = '0; id_out_provide = '0; ext_stall = 1'b0;
    m_of = '0; m_ex = '0; m_wb = '0;
    obs_nop_id = 1'b0; obs_busy = '0;
    @(negedge clk);
    ext_stall = 1'b1;
    push_expect("reset");
    #2;
    pop_compare();
    @(negedge clk);
    ext_stall = 1'b0;
    reset = 1'b1;

    // Independent instructions: busy walks 0x0001 through OF/EX/WB then clears.
    step("indep0", 1'b1, 16'h0000, 16'h0001, 1'b0);
    step("indep1", 1'b1, 16'h0002, 16'h0000, 1'b0);
    check_eq("indep1_nop", 32'(obs_nop_id), 32'd0);
    check_eq("indep1_busy", 32'(obs_busy), 32'h0001);
    step("indep2", 1'b0, 16'h0000, 16'h0000, 1'b0);
    check_eq("indep2_busy", 32'(obs_busy), 32'h0001);
    step("indep3", 1'b0, 16'h0000, 16'h0000, 1'b0);
    check_eq("indep3_busy", 32'(obs_busy), 32'h0001);
    step("indep4", 1'b0, 16'h0000, 16'h0000, 1'b0);
    check_eq("indep4_busy", 32'(obs_busy), 32'h0000);

    // RAW on register 0: three hold cycles, issues in the fourth.
    step("raw0", 1'b1, 16'h0000, 16'h0001, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step("raw_wait", 1'b1, 16'h0001, 16'h0000, 1'b0);
      check_eq("raw_wait_nop", 32'(obs_nop_id), 32'd1);
    end
    step("raw4", 1'b1, 16'h0001, 16'h0000, 1'b0);
    check_eq("raw4_nop", 32'(obs_nop_id), 32'd0);
    idle(3);

    // External freeze over a pending hazard, then the countdown resumes.
    step("xs0", 1'b1, 16'h0000, 16'h0010, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step("xs_frz", 1'b1, 16'h0010, 16'h0000, 1'b1);
      check_eq("xs_frz_busy", 32'(obs_busy), 32'h0010);
    end
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step("xs_run", 1'b1, 16'h0010, 16'h0000, 1'b0);
      if (obs_nop_id == 1'b0) break;
      stall_cnt++;
    end
    check_eq("xs_stall_cnt", 32'(stall_cnt), 32'd3);
    idle(3);

    // Self-dependency does not stall; a following reader waits three cycles.
    step("self0", 1'b1, 16'h0004, 16'h0004, 1'b0);
    check_eq("self0_nop", 32'(obs_nop_id), 32'd0);
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step("self_rd", 1'b1, 16'h0004, 16'h0000, 1'b0);
      if (obs_nop_id == 1'b0) break;
      stall_cnt++;
    end
    check_eq("self_stall_cnt", 32'(stall_cnt), 32'd3);
    idle(3);

    // Invalid ID slot with all-ones request against all-ones busy.
    step("fill0", 1'b1, 16'h0000, 16'hFFFF, 1'b0);
    step("fill1", 1'b1, 16'h0000, 16'hFFFF, 1'b0);
    step("fill2", 1'b1, 16'h0000, 16'hFFFF, 1'b0);
    step("inval", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    check_eq("inval_busy", 32'(obs_busy), 32'hFFFF);
    check_eq("inval_nop", 32'(obs_nop_id), 32'd0);
    idle(3);

    // Asynchronous reset between edges with busy = 0x8001.
    step("ar0", 1'b1, 16'h0000, 16'h8001, 1'b0);
    check_eq("ar0_busy_pre", 32'(busy_mask), 32'h8001);
    async_reset("areset");
    check_eq("areset_busy", 32'(obs_busy), 32'h0000);
    step("post_rst", 1'b1, 16'h8001, 16'h0002, 1'b0);
    check_eq("post_rst_nop", 32'(obs_nop_id), 32'd0);
    idle(3);

    // Reset in the middle of a stall drops the pending hazard.
    step("mr0", 1'b1, 16'h0000, 16'h0020, 1'b0);
    step("mr1", 1'b1, 16'h0020, 16'h0000, 1'b0);
    check_eq("mr1_nop", 32'(obs_nop_id), 32'd1);
    async_reset("mreset");
    step("mr2", 1'b1, 16'h0020, 16'h0000, 1'b0);
    check_eq("mr2_nop", 32'(obs_nop_id), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [NREGS-1:0] rq, pv;
      rq = NREGS'(1) << $urandom_range(NREGS - 1);
      pv = NREGS'(1) << $urandom_range(NREGS - 1);
      if ($urandom_range(3) == 0) rq = '0;
      step("rnd", 1'($urandom_range(1)), rq, pv, ($urandom_range(7) == 0));
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
